// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM for the CPU load/store port, with
// programmable wait states, byte-enabled stores and misaligned/out-of-range errors.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   state_t                state_q;
   logic [3:0]            cnt_q, be_q, e_be;
   logic                  ready_q, valid_q, err_q, we_q;
   logic [31:0]           rdata_q, addr_q, wdata_q, e_addr, e_wdata;
   logic [31:0]           mem [2**ADDR_WIDTH];
   logic                  accept, go_resp, e_we, err_c, wen;
   logic [ADDR_WIDTH-1:0] idx;
   assign req_ready = ready_q;
   assign rsp_valid = valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign accept    = state_q == IDLE && req_valid && ready_q;
   // With zero wait states the request is evaluated straight off the port on its accept edge.
   assign e_we    = (state_q == IDLE) ? req_we : we_q;
   assign e_addr  = (state_q == IDLE) ? req_addr : addr_q;
   assign e_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
   assign e_be    = (state_q == IDLE) ? req_be : be_q;
   assign go_resp = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
   assign err_c   = e_addr[1:0] != 2'b00 || (e_addr >> (ADDR_WIDTH + 2)) != 32'd0;
   assign idx     = e_addr[ADDR_WIDTH+1:2];
   assign wen     = go_resp && e_we && !err_c;
   always_ff @(posedge clock)
      if (wen)
         for (int i = 0; i < 4; i++)
            if (e_be[i]) mem[idx][8*i +: 8] <= e_wdata[8*i +: 8];
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= !accept;
               if (accept) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  cnt_q   <= CNT_INIT;
                  state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_q   <= (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
               state_q <= (cnt_q == 4'd0) ? RESP : WAIT;
            end
            RESP:
               if (rsp_ready) begin
                  valid_q <= 1'b0;
                  err_q   <= 1'b0;
                  rdata_q <= 32'd0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            default: state_q <= IDLE;
         endcase
         if (go_resp) begin
            valid_q <= 1'b1;
            err_q   <= err_c;
            rdata_q <= (err_c || e_we) ? 32'd0 : mem[idx];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: lane 0 runs WAIT_CYCLES=1, lane 1 runs WAIT_CYCLES=0; a
// scoreboard queue per lane is checked by a monitor on every falling edge.
module tb_dmem_responder;
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      longint      t;
   } exp_t;
   logic        clock = 1'b0;
   logic        reset_n;
   logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic [31:0] rsp_rdata [2];
   logic [3:0]  req_be [2];
   exp_t        sb [2][$];
   exp_t        cur;
   bit   [1:0]  seen;
   int          tests = 0;
   int          fails = 0;
   longint      t, t0, t1;
   always #5 clock = ~clock;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(g == 0 ? 1 : 0)) u_dut (
         .clock(clock), .reset_n(reset_n),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
         .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_be(req_be[g]),
         .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
         .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]));
   end
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask
   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic req(input int k, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] er, input bit ee,
                      input bit push, output longint ta);
      req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_be[k] = be;
      ta = -1;
      for (int n = 0; n < 50 && ta < 0; n++) begin
         @(negedge clock);
         if (req_ready[k]) ta = $time + 5;
      end
      if (ta < 0) chk("accept_timeout", 32'd0, 32'd1);
      else if (push) sb[k].push_back('{er, ee, ta});
      @(posedge clock); #1;
      req_valid[k] = 1'b0;
   endtask
   task automatic drain();
      for (int n = 0; n < 100 && (sb[0].size() + sb[1].size()) != 0; n++) @(negedge clock);
      @(posedge clock); #1;
   endtask
   always @(negedge clock) begin
      if (!reset_n) seen = 2'b00;
      else
         for (int k = 0; k < 2; k++)
            if (rsp_valid[k]) begin
               if (sb[k].size() == 0) chk("unexpected_rsp", 32'(rsp_valid[k]), 32'd0);
               else begin
                  cur = sb[k][0];
                  if (!seen[k]) begin
                     seen[k] = 1'b1;
                     chk("latency", 32'($time - cur.t), (k == 0) ? 32'd15 : 32'd5);
                  end
                  chk("rsp_rdata", rsp_rdata[k], cur.rdata);
                  chk("rsp_err", 32'(rsp_err[k]), 32'(cur.err));
                  if (rsp_ready[k]) begin
                     cur = sb[k].pop_front();
                     seen[k] = 1'b0;
                  end
               end
            end
   end
   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
   initial begin
      reset_n = 1'b0; req_valid = 2'b00; req_we = 2'b00; rsp_ready = 2'b11;
      for (int k = 0; k < 2; k++) begin
         req_addr[k] = 32'd0; req_wdata[k] = 32'd0; req_be[k] = 4'd0;
      end
      #23;
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[0], 32'd0);
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock); #1;
      chk("ready_after_reset", 32'(req_ready), 32'd3);
      req(0, 1, 32'h0, 32'h0BADF00D, 4'hF, 32'd0, 0, 1, t);
      req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 0, 1, t);
      req(0, 0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 0, 1, t);
      req(0, 1, 32'h10, 32'h000000AA, 4'h1, 32'd0, 0, 1, t);
      req(0, 0, 32'h10, 32'd0, 4'h0, 32'hDEADBEAA, 0, 1, t);
      req(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'd0, 0, 1, t);
      req(0, 0, 32'h10, 32'd0, 4'hF, 32'hDEADBEAA, 0, 1, t);
      req(0, 1, 32'h4, 32'h11223344, 4'hF, 32'd0, 0, 1, t);
      req(0, 1, 32'h4, 32'hAABBCCDD, 4'h6, 32'd0, 0, 1, t);
      req(0, 0, 32'h4, 32'd0, 4'hF, 32'h11BBCC44, 0, 1, t);
      req(0, 0, 32'h12, 32'd0, 4'hF, 32'd0, 1, 1, t);
      req(0, 0, 32'h400, 32'd0, 4'hF, 32'd0, 1, 1, t);
      req(0, 1, 32'h400, 32'h12345678, 4'hF, 32'd0, 1, 1, t);
      req(0, 1, 32'h13, 32'h12345678, 4'hF, 32'd0, 1, 1, t);
      req(0, 0, 32'h80000000, 32'd0, 4'hF, 32'd0, 1, 1, t);
      req(0, 0, 32'h0, 32'd0, 4'hF, 32'h0BADF00D, 0, 1, t);
      req(0, 1, 32'h3FC, 32'hA5A5C3C3, 4'hF, 32'd0, 0, 1, t);
      req(0, 0, 32'h3FC, 32'd0, 4'hF, 32'hA5A5C3C3, 0, 1, t);
      drain();
      rsp_ready[0] = 1'b0;
      req(0, 0, 32'h10, 32'd0, 4'hF, 32'hDEADBEAA, 0, 1, t);
      for (int n = 0; n < 7; n++) begin
         @(negedge clock);
         chk("ready_low_in_hold", 32'(req_ready[0]), 32'd0);
      end
      @(posedge clock); #1;
      rsp_ready[0] = 1'b1;
      t0 = $time;
      req(0, 0, 32'h4, 32'd0, 4'hF, 32'h11BBCC44, 0, 1, t);
      chk("accept_after_rsp", 32'(t - t0), 32'd19);
      req(1, 1, 32'h8, 32'hCAFEBABE, 4'hF, 32'd0, 0, 1, t);
      req(1, 0, 32'h8, 32'd0, 4'hF, 32'hCAFEBABE, 0, 1, t1);
      req(1, 0, 32'h9, 32'd0, 4'hF, 32'd0, 1, 1, t);
      chk("back_to_back", 32'(t - t1), 32'd20);
      drain();
      req(0, 1, 32'h20, 32'h55AA55AA, 4'hF, 32'd0, 0, 1, t);
      drain();
      req(0, 1, 32'h20, 32'h01234567, 4'hF, 32'd0, 0, 0, t);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("abort_req_ready", 32'(req_ready[0]), 32'd0);
      chk("abort_rsp_rdata", rsp_rdata[0], 32'd0);
      @(negedge clock);
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock); #1;
      chk("ready_after_abort", 32'(req_ready), 32'd3);
      req(0, 0, 32'h20, 32'd0, 4'hF, 32'h55AA55AA, 0, 1, t);
      drain();
      chk("scoreboard_drained", 32'(sb[0].size() + sb[1].size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
